// File: rtl/logic_word_pipe_pkg.sv
// Shared opcode constants and types for logic_word_pipe.
// Contents: op_t, OP_AND..OP_CLR_ACC, used by the decoder, the top and the bench.
package logic_word_pipe_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_AND     = 3'd0;
   localparam op_t OP_OR      = 3'd1;
   localparam op_t OP_XOR     = 3'd2;
   localparam op_t OP_NOR     = 3'd3;
   localparam op_t OP_ANDN    = 3'd4;
   localparam op_t OP_PASS_A  = 3'd5;
   localparam op_t OP_OR_ACC  = 3'd6;
   localparam op_t OP_CLR_ACC = 3'd7;

endpackage

// File: rtl/logic_word_pipe_if.sv
// Valid/ready bus of logic_word_pipe: operand side (in_*, a, b, op) and result side.
// master = upstream/downstream environment, slave = the logic unit.
interface logic_word_pipe_if
   import logic_word_pipe_pkg::*;
#(
   parameter int WIDTH = 20
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_t              op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             zero;
   logic             neg;
   logic             parity;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, c, zero, neg, parity
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, c, zero, neg, parity
   );

endinterface

// File: rtl/logic_core.sv
// Combinational logic op, flags and accumulator next-state.
// Ports: a_i, b_i, op_i, acc_i -> c_o, zero_o, neg_o, parity_o, acc_next_o, acc_we_o.
module logic_core
   import logic_word_pipe_pkg::*;
#(
   parameter int WIDTH = 20
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  op_t              op_i,
   input  logic [WIDTH-1:0] acc_i,
   output logic [WIDTH-1:0] c_o,
   output logic             zero_o,
   output logic             neg_o,
   output logic             parity_o,
   output logic [WIDTH-1:0] acc_next_o,
   output logic             acc_we_o
);

   logic [WIDTH-1:0] or_acc;

   assign or_acc = acc_i | a_i;

   always_comb begin
      c_o        = '0;
      acc_next_o = acc_i;
      acc_we_o   = 1'b0;
      unique case (op_i)
         OP_AND:    c_o = a_i & b_i;
         OP_OR:     c_o = a_i | b_i;
         OP_XOR:    c_o = a_i ^ b_i;
         OP_NOR:    c_o = ~(a_i | b_i);
         OP_ANDN:   c_o = a_i & ~b_i;
         OP_PASS_A: c_o = a_i;
         OP_OR_ACC: begin
            c_o        = or_acc;
            acc_next_o = or_acc;
            acc_we_o   = 1'b1;
         end
         OP_CLR_ACC: begin
            c_o        = '0;
            acc_next_o = '0;
            acc_we_o   = 1'b1;
         end
      endcase
   end

   assign zero_o   = (c_o == '0);
   assign neg_o    = c_o[WIDTH-1];
   assign parity_o = ^c_o;

endmodule

// File: rtl/logic_word_pipe.sv
// Two-stage pipelined bitwise logic unit with OR-accumulator.
// Ports: clk, rst (sync, active high), bus (slave side of logic_word_pipe_if).
module logic_word_pipe
   import logic_word_pipe_pkg::*;
#(
   parameter int WIDTH = 20
) (
   input logic              clk,
   input logic              rst,
   logic_word_pipe_if.slave bus
);

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   op_t              s1_op_q;

   logic             s2_valid_q;
   logic [WIDTH-1:0] c_q;
   logic             zero_q;
   logic             neg_q;
   logic             parity_q;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic             acc_we;

   logic [WIDTH-1:0] c_d;
   logic             zero_d;
   logic             neg_d;
   logic             parity_d;

   logic             s1_en;
   logic             s2_en;

   // S2 frees up when empty or draining; S1 follows.
   assign s2_en = !s2_valid_q || bus.out_ready;
   assign s1_en = !s1_valid_q || s2_en;

   assign bus.in_ready  = s1_en;
   assign bus.out_valid = s2_valid_q;
   assign bus.c         = c_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
   assign bus.parity    = parity_q;

   logic_core #(.WIDTH(WIDTH)) u_core (
      .a_i        (s1_a_q),
      .b_i        (s1_b_q),
      .op_i       (s1_op_q),
      .acc_i      (acc_q),
      .c_o        (c_d),
      .zero_o     (zero_d),
      .neg_o      (neg_d),
      .parity_o   (parity_d),
      .acc_next_o (acc_d),
      .acc_we_o   (acc_we)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= OP_AND;
         s2_valid_q <= 1'b0;
         c_q        <= '0;
         zero_q     <= 1'b0;
         neg_q      <= 1'b0;
         parity_q   <= 1'b0;
         acc_q      <= '0;
      end else begin
         if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
               s1_a_q  <= bus.a;
               s1_b_q  <= bus.b;
               s1_op_q <= bus.op;
            end
         end
         if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            // acc moves only with its own transaction, keeping order.
            if (s1_valid_q) begin
               c_q      <= c_d;
               zero_q   <= zero_d;
               neg_q    <= neg_d;
               parity_q <= parity_d;
               if (acc_we) acc_q <= acc_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_logic_word_pipe.sv
// Self-checking bench for logic_word_pipe: directed cases plus random traffic
// against a transaction-level reference model.
module tb_logic_word_pipe;
   import logic_word_pipe_pkg::*;

   localparam int W = 20;

   typedef struct {
      logic [W-1:0] c;
      logic         z;
      logic         n;
      logic         p;
      int           t;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic_word_pipe_if #(.WIDTH(W)) bus ();

   logic_word_pipe #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int accepts = 0;
   int last_lat = 0;
   int last_pop = 0;
   int prev_pop = 0;

   exp_t         q[$];
   logic [W-1:0] got_log[$];
   logic [W-1:0] macc = '0;
   logic [W-1:0] last_c = '0;
   logic         last_z, last_n, last_p;
   logic         stall_prev = 1'b0;
   logic [W-1:0] hold_c = '0;

   task automatic expect_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                  tag, got, exp, cyc_n);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input op_t op);
      logic [W-1:0] r;
      logic [W-1:0] ones;
      ones = '1;
      case (op)
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_XOR:    r = a ^ b;
         OP_NOR:    r = ones - (a | b);
         OP_ANDN:   r = a & (ones - b);
         OP_PASS_A: r = a;
         OP_OR_ACC: begin macc = macc | a; r = macc; end
         default:   begin macc = '0; r = '0; end
      endcase
      return r;
   endfunction

   task automatic cyc();
      exp_t e;
      logic [W-1:0] r;
      #1;
      if (!rst) begin
         expect_eq("in_ready", 32'(bus.in_ready),
                   32'((q.size() < 2) || bus.out_ready));
         if (stall_prev) begin
            expect_eq("hold_v", 32'(bus.out_valid), 32'd1);
            expect_eq("hold_c", 32'(bus.c), 32'(hold_c));
         end
         if (q.size() == 0)
            expect_eq("ov_idle", 32'(bus.out_valid), 32'd0);
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            expect_eq("c", 32'(bus.c), 32'(e.c));
            expect_eq("zero", 32'(bus.zero), 32'(e.z));
            expect_eq("neg", 32'(bus.neg), 32'(e.n));
            expect_eq("parity", 32'(bus.parity), 32'(e.p));
            last_c   = bus.c;
            last_z   = bus.zero;
            last_n   = bus.neg;
            last_p   = bus.parity;
            last_lat = cyc_n - e.t;
            prev_pop = last_pop;
            last_pop = cyc_n;
            got_log.push_back(bus.c);
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         hold_c     = bus.c;
         if (bus.in_valid && bus.in_ready) begin
            r   = ref_op(bus.a, bus.b, bus.op);
            e.c = r;
            e.z = (r == 0);
            e.n = (r >= (1 << (W - 1)));
            e.p = ($countones(r) % 2) == 1;
            e.t = cyc_n;
            q.push_back(e);
            accepts++;
         end
      end else begin
         q.delete();
         macc       = '0;
         stall_prev = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input op_t op,
                        input logic ordy);
      bus.in_valid  = v;
      bus.a         = a;
      bus.b         = b;
      bus.op        = op;
      bus.out_ready = ordy;
   endtask

   task automatic drain();
      drive(1'b0, '0, '0, OP_AND, 1'b1);
      for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
      expect_eq("drain_to", 32'(q.size()), 32'd0);
   endtask

   initial begin
      drive(1'b1, 20'h12345, 20'h54321, OP_OR, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      drive(1'b0, '0, '0, OP_AND, 1'b1);
      #1;
      expect_eq("rst_ov", 32'(bus.out_valid), 32'd0);
      expect_eq("rst_c", 32'(bus.c), 32'd0);
      expect_eq("rst_flags",
                32'({bus.zero, bus.neg, bus.parity}), 32'd0);
      expect_eq("rst_ir", 32'(bus.in_ready), 32'd1);
      cyc();

      drive(1'b1, 20'hAAAAA, 20'h55555, OP_OR, 1'b1);
      cyc();
      drain();
      expect_eq("or_c", 32'(last_c), 32'hFFFFF);
      expect_eq("or_flags", 32'({last_z, last_n, last_p}), 32'b010);
      expect_eq("or_lat", 32'(last_lat), 32'd2);

      drive(1'b1, 20'h12345, 20'h12345, OP_XOR, 1'b1);
      cyc();
      drive(1'b1, 20'h0, 20'h0, OP_NOR, 1'b1);
      cyc();
      got_log.delete();
      drain();
      expect_eq("xn_n", 32'(got_log.size()), 32'd2);
      if (got_log.size() == 2) begin
         expect_eq("xor_c", 32'(got_log[0]), 32'd0);
         expect_eq("nor_c", 32'(got_log[1]), 32'hFFFFF);
      end
      expect_eq("b2b", 32'(last_pop - prev_pop), 32'd1);
      expect_eq("nor_neg", 32'(last_n), 32'd1);

      accepts = 0;
      got_log.delete();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 20'hF0F0F + W'(i), 20'hFF00F, OP_AND, 1'b0);
         cyc();
      end
      expect_eq("bp_acc", 32'(accepts), 32'd2);
      expect_eq("bp_ir", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 20'hF0F0F + W'(2), 20'hFF00F, OP_AND, 1'b1);
      for (int i = 0; i < 5 && accepts < 3; i++) cyc();
      drain();
      expect_eq("bp_out", 32'(got_log.size()), 32'd3);

      got_log.delete();
      drive(1'b1, 20'h0, 20'hABCDE, OP_CLR_ACC, 1'b1);
      cyc();
      drive(1'b1, 20'h00F00, 20'h0, OP_OR_ACC, 1'b0);
      cyc();
      drive(1'b1, 20'h0000F, 20'h0, OP_OR_ACC, 1'b0);
      cyc();
      cyc();
      drive(1'b1, 20'h0000F, 20'h0, OP_OR_ACC, 1'b1);
      cyc();
      drain();
      expect_eq("acc_n", 32'(got_log.size()), 32'd3);
      if (got_log.size() == 3) begin
         expect_eq("acc0", 32'(got_log[0]), 32'h0);
         expect_eq("acc1", 32'(got_log[1]), 32'h00F00);
         expect_eq("acc2", 32'(got_log[2]), 32'h00F0F);
      end

      drive(1'b1, 20'h00001, 20'h0, OP_OR_ACC, 1'b0);
      cyc();
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      drive(1'b0, '0, '0, OP_AND, 1'b1);
      #1;
      expect_eq("mid_rst_ov", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 20'h00001, 20'h0, OP_OR_ACC, 1'b1);
      cyc();
      drain();
      expect_eq("post_rst_acc", 32'(last_c), 32'h00001);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
               op_t'($urandom_range(0, 7)),
               $urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 63) == 0);
         cyc();
      end
      rst = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
